fetch_aligner: RTL
==================

// Module: fetch_aligner
// PURPOSE
//  Read side of the instruction prefetch FIFO (sync_fifo, DATA_WIDTH=32). Pops 32-bit fetch words
//  and re-aligns them into RV32IC instructions (16-bit compressed or 32-bit, halfword aligned).
//  Also tracks each instruction's PC and presents it to decode on a valid/ready handshake.
//  Branch redirects clear the FIFO and restart alignment at the new PC.
// PARAMETERS
//  BOOT_ADDR   32'h0000_0000   PC after reset; BOOT_ADDR[1:0] must be 2'b00
// PORTS
//  clk               in   1   clock
//  reset_n           in   1   asynchronous, active-low reset
//  fifo_rd_data      in   32  FIFO head word (entry 0); meaningful when !fifo_empty
//  fifo_empty        in   1   FIFO empty
//  fifo_rd_en        out  1   pop FIFO head this cycle
//  fifo_clear        out  1   flush FIFO (driven on redirect)
//  redirect_valid    in   1   branch/jump/trap redirect, single-cycle pulse
//  redirect_pc       in   32  redirect target; bit0 ignored (treated as 0)
//  instr_valid       out  1   instr/instr_pc/instr_compressed valid
//  instr_ready       in   1   decode accepts; handshake = instr_valid & instr_ready
//  instr             out  32  instruction; compressed form zero-extended in [31:16]
//  instr_pc          out  32  PC of instr
//  instr_compressed  out  1   instr is 16-bit (instr[1:0] != 2'b11)
// BEHAVIOUR
//  - Registered state: st_q {ALIGNED, RESID, SKIP}, resid_q[15:0] (upper half of last popped word), pc_q[31:0].
//  - Reset: st_q=ALIGNED, resid_q=0, pc_q=BOOT_ADDR. With empty FIFO and no redirect:
//    instr_valid=0, fifo_rd_en=0, fifo_clear=0, instr_pc=BOOT_ADDR.
//  - W = fifo_rd_data. Let C(x) = (x[1:0] != 2'b11).
//  - ALIGNED: valid = !fifo_empty.
//    C(W[15:0]): instr={16'h0,W[15:0]}. On handshake: pop, resid_q<=W[31:16], ->RESID.
//    Otherwise: instr=W. On handshake: pop, stay ALIGNED.
//  - RESID: C(resid_q): instr={16'h0,resid_q}, valid=1 independent of FIFO. On handshake: no pop, ->ALIGNED.
//    Otherwise: instr={W[15:0],resid_q}, valid=!fifo_empty. On handshake: pop, resid_q<=W[31:16], stay RESID.
//  - SKIP (target pc[1]=1): instr_valid=0. When !fifo_empty: pop, resid_q<=W[31:16], ->RESID.
//    One bubble cycle; pc_q unchanged.
//  - On handshake pc_q <= pc_q + (instr_compressed ? 2 : 4), 32-bit wrap-around.
//  - instr_pc = pc_q combinationally. No-handshake latency: FIFO head -> instr_valid same cycle.
//  - fifo_rd_en only when !fifo_empty; at most one pop per cycle; never pops without consuming data.
//  - Stall (valid & !ready): instr, instr_pc and instr_compressed hold stable. The FIFO head is
//    not popped, so it holds. Once asserted, valid never drops without a handshake, except on redirect.
//  - Redirect (highest priority): fifo_clear=redirect_valid combinationally. The same cycle forces
//    instr_valid=0 and fifo_rd_en=0, and no handshake occurs.
//    Next state: pc_q<={redirect_pc[31:1],1'b0}; st_q<=redirect_pc[1] ? SKIP : ALIGNED; resid_q<=0.
//    Back-to-back redirects: the last one wins.
//  - Data popped or registered before a redirect is discarded; the FIFO only holds post-redirect
//    fetch words from the cycle after fifo_clear.
//  - Reset mid-operation: all state returns to reset values immediately (asynchronously); resid_q is lost.
// TESTING
//  1. Push 0x00000013 x3, ready=1 -> 3 instrs 0x00000013 at pc 0,4,8; 3 rd_en pulses; compressed=0.
//  2. Push 0x45050001 -> 0x0001 @pc0 then 0x4505 @pc2, both compressed; exactly one rd_en,
//     asserted with the first instruction.
//  3. Push 0x05130001, then 0x00000000 one cycle later -> 0x0001 @0, 0x00000513 @2 (pop on this one), 0x0000 @6.
//     The second instruction is not valid until the second word arrives.
//  4. Valid instr with ready=0 for 5 cycles -> instr/pc/compressed constant, no rd_en;
//     ready=1 -> single handshake, pc advances once.
//  5. Redirect to 0x00000102 while stalled -> fifo_clear 1 cycle, valid=0. Push 0x00011234 ->
//     1 bubble with pop (0x1234 dropped), then 0x0001 @0x102, then ALIGNED fetch @0x104.
//  6. Assert reset_n=0 in RESID with a 32-bit resid_q and an empty FIFO -> instr_valid=0,
//     instr_pc=BOOT_ADDR. Push 0x00000013 -> 0x00000013 @BOOT_ADDR (no stale halfword).

Source files
------------

// File: rtl/fetch_aligner.sv
// Instruction fetch aligner: pops 32-bit fetch words from the prefetch FIFO and
// re-aligns them into RV32IC instructions with their PCs for decode.
module fetch_aligner #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] fifo_rd_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        fifo_clear,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_compressed
);

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    RESID   = 2'd1,
    SKIP    = 2'd2
  } state_e;

  state_e      st_q,    st_d;
  logic [15:0] resid_q, resid_d;
  logic [31:0] pc_q,    pc_d;

  logic        valid;
  logic        comp;
  logic        hs;
  logic        lo_c;
  logic        res_c;

  assign lo_c  = (fifo_rd_data[1:0] != 2'b11);
  assign res_c = (resid_q[1:0] != 2'b11);

  always_comb begin
    st_d       = st_q;
    resid_d    = resid_q;
    pc_d       = pc_q;
    valid      = 1'b0;
    comp       = 1'b0;
    instr      = '0;
    fifo_rd_en = 1'b0;

    unique case (st_q)
      ALIGNED: begin
        valid = !fifo_empty;
        if (lo_c) begin
          instr = {16'h0000, fifo_rd_data[15:0]};
          comp  = 1'b1;
        end else begin
          instr = fifo_rd_data;
        end
      end
      RESID: begin
        // A compressed residual is self-contained and needs no FIFO word.
        if (res_c) begin
          instr = {16'h0000, resid_q};
          comp  = 1'b1;
          valid = 1'b1;
        end else begin
          instr = {fifo_rd_data[15:0], resid_q};
          valid = !fifo_empty;
        end
      end
      default: ;
    endcase

    if (redirect_valid) valid = 1'b0;
    hs = valid & instr_ready;

    if (hs) begin
      pc_d = pc_q + (comp ? 32'd2 : 32'd4);
      if (st_q == ALIGNED) begin
        fifo_rd_en = 1'b1;
        if (comp) begin
          resid_d = fifo_rd_data[31:16];
          st_d    = RESID;
        end
      end else if (st_q == RESID) begin
        if (comp) begin
          st_d = ALIGNED;
        end else begin
          fifo_rd_en = 1'b1;
          resid_d    = fifo_rd_data[31:16];
        end
      end
    end

    // Odd-halfword target: drop the low half of the first word, keep the upper.
    if (st_q == SKIP && !fifo_empty && !redirect_valid) begin
      fifo_rd_en = 1'b1;
      resid_d    = fifo_rd_data[31:16];
      st_d       = RESID;
    end

    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:1], 1'b0};
      st_d    = redirect_pc[1] ? SKIP : ALIGNED;
      resid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= ALIGNED;
      resid_q <= '0;
      pc_q    <= BOOT_ADDR;
    end else begin
      st_q    <= st_d;
      resid_q <= resid_d;
      pc_q    <= pc_d;
    end
  end

  assign fifo_clear       = redirect_valid;
  assign instr_valid      = valid;
  assign instr_compressed = comp;
  assign instr_pc         = pc_q;

endmodule
